// File: rtl/norm_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : norm_arbiter
// Brief    : Round-robin arbiter in front of one shared two-stage normalizer
//            (leading-zero count, left shift, exponent adjust). The optional
//            macro NORM_UNDERFLOW_CLAMP_EN switches underflow results to
//            subnormal outputs instead of flagging them.
// Revision : 1.0 - initial release
// ============================================================================
module norm_arbiter #(
    parameter int num_round_bits = 8,
    parameter int exp_width      = 8,
    parameter int mant_width     = 23,
    localparam int W             = mant_width + num_round_bits + 1,
    localparam int E             = exp_width + 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in0_valid,
    output logic         in0_ready,
    input  logic [W-1:0] in0_mant,
    input  logic [E-1:0] in0_exp,
    input  logic         in1_valid,
    output logic         in1_ready,
    input  logic [W-1:0] in1_mant,
    input  logic [E-1:0] in1_exp,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_mant,
    output logic [E-1:0] out_exp,
    output logic         out_tag,
    output logic         out_zero,
    output logic         out_uflow
);

    localparam int c_p  = (W <= 8) ? 8 : (W <= 16) ? 16 : (W <= 32) ? 32 : 64;
    localparam int c_lw = $clog2(c_p) + 1;

    logic            r_last;
    logic            r_s1_valid;
    logic [W-1:0]    r_s1_mant;
    logic [E-1:0]    r_s1_exp;
    logic            r_s1_tag;
    logic [c_lw-1:0] r_s1_lzc;
    logic            r_s2_valid;
    logic [W-1:0]    r_s2_mant;
    logic [E-1:0]    r_s2_exp;
    logic            r_s2_tag;
    logic            r_s2_zero;
    logic            r_s2_uflow;

    logic            w_s2_load;
    logic            w_s1_load;
    logic            w_gnt1;
    logic            w_accept;
    logic [W-1:0]    w_mant;
    logic [E-1:0]    w_exp;
    logic [c_p-1:0]  w_pad;
    logic [c_lw-1:0] w_lzc;
    logic [E-1:0]    w_diff;
    logic [c_lw-1:0] w_shamt;
    logic [W-1:0]    w_n_mant;
    logic [E-1:0]    w_n_exp;
    logic            w_n_zero;
    logic            w_n_uflow;

    assign w_s2_load = !r_s2_valid || out_ready;
    assign w_s1_load = !r_s1_valid || w_s2_load;

    // r_last=1 means requester 1 was granted last, so requester 0 wins a tie
    assign w_gnt1    = in1_valid && (!in0_valid || !r_last);
    assign in0_ready = !rst && w_s1_load && in0_valid && !w_gnt1;
    assign in1_ready = !rst && w_s1_load && w_gnt1;
    assign w_accept  = in0_ready || in1_ready;

    assign w_mant = w_gnt1 ? in1_mant : in0_mant;
    assign w_exp  = w_gnt1 ? in1_exp  : in0_exp;

    // LSB zero-padding keeps the leading-zero count of the real bits intact
    assign w_pad = c_p'(w_mant) << (c_p - W);

    always_comb begin
        w_lzc = c_lw'(c_p);
        for (int i = 0; i < c_p; i++) begin
            if (w_pad[i]) begin
                w_lzc = c_lw'(c_p - 1 - i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_last     <= 1'b1;
            r_s1_valid <= 1'b0;
            r_s1_mant  <= '0;
            r_s1_exp   <= '0;
            r_s1_tag   <= 1'b0;
            r_s1_lzc   <= '0;
        end else begin
            if (w_s1_load) begin
                r_s1_valid <= w_accept;
                if (w_accept) begin
                    r_s1_mant <= w_mant;
                    r_s1_exp  <= w_exp;
                    r_s1_tag  <= w_gnt1;
                    r_s1_lzc  <= w_lzc;
                end
            end
            if (w_accept) begin
                r_last <= w_gnt1;
            end
        end
    end

    assign w_diff = r_s1_exp - E'(r_s1_lzc);

    always_comb begin
        w_shamt   = r_s1_lzc;
        w_n_exp   = w_diff;
        w_n_uflow = 1'b0;
        w_n_zero  = 1'b0;
`ifdef NORM_UNDERFLOW_CLAMP_EN
        // Shift only as far as the exponent allows; the result is subnormal
        if (E'(r_s1_lzc) >= r_s1_exp) begin
            w_shamt = (r_s1_exp != '0) ? c_lw'(r_s1_exp - 1'b1) : '0;
            w_n_exp = '0;
        end
`else
        if (w_diff[E-1] || (w_diff == '0)) begin
            w_n_exp   = '0;
            w_n_uflow = 1'b1;
        end
`endif
        w_n_mant = r_s1_mant << w_shamt;
        if (r_s1_mant == '0) begin
            w_n_mant  = '0;
            w_n_exp   = '0;
            w_n_uflow = 1'b0;
            w_n_zero  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s2_valid <= 1'b0;
            r_s2_mant  <= '0;
            r_s2_exp   <= '0;
            r_s2_tag   <= 1'b0;
            r_s2_zero  <= 1'b0;
            r_s2_uflow <= 1'b0;
        end else if (w_s2_load) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_mant  <= w_n_mant;
                r_s2_exp   <= w_n_exp;
                r_s2_tag   <= r_s1_tag;
                r_s2_zero  <= w_n_zero;
                r_s2_uflow <= w_n_uflow;
            end
        end
    end

    assign out_valid = r_s2_valid;
    assign out_mant  = r_s2_mant;
    assign out_exp   = r_s2_exp;
    assign out_tag   = r_s2_tag;
    assign out_zero  = r_s2_zero;
    assign out_uflow = r_s2_uflow;

endmodule
`default_nettype wire

// File: tb/tb_norm_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_norm_arbiter
// Brief    : Directed self-checking bench for norm_arbiter (W=32, E=10).
// Revision : 1.0 - initial release
// ============================================================================
module tb_norm_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        in0_valid, in1_valid;
    logic        in0_ready, in1_ready;
    logic [31:0] in0_mant, in1_mant;
    logic [9:0]  in0_exp, in1_exp;
    logic        out_valid, out_ready;
    logic [31:0] out_mant;
    logic [9:0]  out_exp;
    logic        out_tag, out_zero, out_uflow;

    int total = 0;
    int bad   = 0;

    norm_arbiter #(
        .num_round_bits(8),
        .exp_width     (8),
        .mant_width    (23)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in0_valid (in0_valid),
        .in0_ready (in0_ready),
        .in0_mant  (in0_mant),
        .in0_exp   (in0_exp),
        .in1_valid (in1_valid),
        .in1_ready (in1_ready),
        .in1_mant  (in1_mant),
        .in1_exp   (in1_exp),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_mant  (out_mant),
        .out_exp   (out_exp),
        .out_tag   (out_tag),
        .out_zero  (out_zero),
        .out_uflow (out_uflow)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic chk_out(input string tag, input logic [31:0] xm, input logic [9:0] xe,
                           input logic xt, input logic xz, input logic xu);
        chk({tag, "_valid"}, out_valid, 1);
        chk({tag, "_mant"},  out_mant,  xm);
        chk({tag, "_exp"},   out_exp,   xe);
        chk({tag, "_tag"},   out_tag,   xt);
        chk({tag, "_zero"},  out_zero,  xz);
        chk({tag, "_uflow"}, out_uflow, xu);
    endtask

    task automatic single(input string tag, input logic req, input logic [31:0] m,
                          input logic [9:0] e, input logic [31:0] xm, input logic [9:0] xe,
                          input logic xz, input logic xu);
        if (req) begin
            in1_valid = 1'b1; in1_mant = m; in1_exp = e;
        end else begin
            in0_valid = 1'b1; in0_mant = m; in0_exp = e;
        end
        #1;
        chk({tag, "_rdy"}, req ? in1_ready : in0_ready, 1);
        tick();
        in0_valid = 1'b0;
        in1_valid = 1'b0;
        #1;
        chk({tag, "_early"}, out_valid, 0);
        tick();
        chk_out(tag, xm, xe, req, xz, xu);
    endtask

    initial begin
        rst = 1'b1; out_ready = 1'b1;
        in0_valid = 1'b1; in1_valid = 1'b1;
        in0_mant = '0; in0_exp = '0; in1_mant = '0; in1_exp = '0;
        tick();
        chk("rst_rdy0", in0_ready, 0);
        chk("rst_rdy1", in1_ready, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_outs", {out_mant, out_exp, out_tag, out_zero, out_uflow}, 0);
        in0_valid = 1'b0; in1_valid = 1'b0;
        tick();
        rst = 1'b0;

        // single request: lzc=15
        single("single", 1'b0, 32'h0001_0000, 10'd100, 32'h8000_0000, 10'd85, 1'b0, 1'b0);

        // contention from reset: grants alternate starting with requester 0
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        in0_valid = 1'b1; in0_mant = 32'h4000_0000; in0_exp = 10'd20;
        in1_valid = 1'b1; in1_mant = 32'h0000_0003; in1_exp = 10'd100;
        for (int k = 0; k < 6; k++) begin
            if (k == 4) begin
                in0_valid = 1'b0; in1_valid = 1'b0;
            end
            #1;
            if (k < 4) begin
                chk($sformatf("cont_rdy0_%0d", k), in0_ready, (k % 2) == 0);
                chk($sformatf("cont_rdy1_%0d", k), in1_ready, (k % 2) == 1);
            end
            if (k >= 2) begin
                chk($sformatf("cont_valid_%0d", k), out_valid, 1);
                chk($sformatf("cont_tag_%0d", k), out_tag, (k % 2) == 1);
                chk($sformatf("cont_exp_%0d", k), out_exp, ((k % 2) == 1) ? 70 : 19);
                chk($sformatf("cont_mant_%0d", k), out_mant,
                    ((k % 2) == 1) ? 32'hC000_0000 : 32'h8000_0000);
            end
            tick();
        end
        chk("cont_drain", out_valid, 0);

        // backpressure: two acceptances fill S1/S2, then everything stalls
        out_ready = 1'b0;
        in0_valid = 1'b1; in0_mant = 32'h0000_0100; in0_exp = 10'd40;
        in1_valid = 1'b1; in1_mant = 32'h00FF_FFFF; in1_exp = 10'd9;
        for (int p = 0; p < 5; p++) begin
            #1;
            chk($sformatf("bp_rdy0_%0d", p), in0_ready, p == 0);
            chk($sformatf("bp_rdy1_%0d", p), in1_ready, p == 1);
            if (p >= 2) begin
                chk_out($sformatf("bp_hold_%0d", p), 32'h8000_0000, 10'd17, 1'b0, 1'b0, 1'b0);
            end
            tick();
        end
        out_ready = 1'b1;
        in0_valid = 1'b0; in1_valid = 1'b0;
        #1;
        chk_out("bp_rel0", 32'h8000_0000, 10'd17, 1'b0, 1'b0, 1'b0);
        tick();
        chk_out("bp_rel1", 32'hFFFF_FF00, 10'd1, 1'b1, 1'b0, 1'b0);
        tick();
        chk("bp_drain", out_valid, 0);

        // zero mantissa
        single("zero", 1'b1, 32'h0, 10'd50, 32'h0, 10'd0, 1'b1, 1'b0);

        // underflow and the exp == lzc boundary
`ifdef NORM_UNDERFLOW_CLAMP_EN
        single("uflow", 1'b0, 32'h0000_0001, 10'd10, 32'h0000_0200, 10'd0, 1'b0, 1'b0);
        single("ueq",   1'b1, 32'h0080_0000, 10'd8,  32'h4000_0000, 10'd0, 1'b0, 1'b0);
`else
        single("uflow", 1'b0, 32'h0000_0001, 10'd10, 32'h8000_0000, 10'd0, 1'b0, 1'b1);
        single("ueq",   1'b1, 32'h0080_0000, 10'd8,  32'h8000_0000, 10'd0, 1'b0, 1'b1);
`endif
        tick();

        // reset one cycle after an acceptance drops the result
        in0_valid = 1'b1; in0_mant = 32'h0000_00F0; in0_exp = 10'd60;
        #1;
        chk("mid_rdy", in0_ready, 1);
        tick();
        in0_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int q = 0; q < 3; q++) begin
            #1;
            chk($sformatf("mid_quiet_%0d", q), out_valid, 0);
            tick();
        end
        in0_valid = 1'b1; in0_mant = 32'h8000_0000; in0_exp = 10'd30;
        in1_valid = 1'b1; in1_mant = 32'h8000_0000; in1_exp = 10'd31;
        #1;
        chk("mid_rdy0", in0_ready, 1);
        chk("mid_rdy1", in1_ready, 0);
        tick();
        in0_valid = 1'b0; in1_valid = 1'b0;
        tick();
        chk_out("mid_out", 32'h8000_0000, 10'd30, 1'b0, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
